// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - funct3 codes, FSM states and helpers shared by the M-op issue controller
package muldiv_pkg;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // REM/REMU share funct3[1]; signed divide ops have funct3[0] clear
  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_div(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_special.sv
// rtl/muldiv_special.sv - detects divide-by-zero and signed overflow and supplies the architectural result
module muldiv_special
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  is_special,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic div_by_zero;
  logic overflow;

  always_comb begin
    div_by_zero = is_div(op) && (b == '0);
    overflow    = is_signed_div(op) && (a == MIN_NEG) && (b == '1);
    is_special  = div_by_zero || overflow;
    result      = '0;
    // b==0 and b==-1 are disjoint, so the order here is only for readability
    if (div_by_zero) begin
      result = is_rem(op) ? a : '1;
    end else if (overflow) begin
      result = is_rem(op) ? '0 : a;
    end
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// rtl/muldiv_issue_ctrl.sv - execute-stage issue/stall/writeback control for the iterative mul/div unit
// Optional watchdog and mulTimeout port enabled by MULDIV_TIMEOUT_EN.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  isMulE,
  input  logic [3:0]            aluCtrlE,
  input  logic [DATA_WIDTH-1:0] srcAE,
  input  logic [DATA_WIDTH-1:0] srcBE,
  input  logic [4:0]            rdE,
  input  logic                  flushE,
  output logic                  mulReq,
  output logic [DATA_WIDTH-1:0] mulA,
  output logic [DATA_WIDTH-1:0] mulB,
  output logic [2:0]            mulOp,
  input  logic                  mulDone,
  input  logic [DATA_WIDTH-1:0] mulResult,
  output logic                  stallMul,
  output logic                  resValid,
  output logic [DATA_WIDTH-1:0] resData,
`ifdef MULDIV_TIMEOUT_EN
  output logic [4:0]            resRd,
  output logic                  mulTimeout
`else
  output logic [4:0]            resRd
`endif
);

  muldiv_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;

  logic                  spec_hit;
  logic [DATA_WIDTH-1:0] spec_result;

`ifdef MULDIV_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             unused_inputs;
  assign unused_inputs = aluCtrlE[3];
`else
  logic unused_inputs;
  assign unused_inputs = aluCtrlE[3] ^ (TIMEOUT_CYCLES == 0);
`endif

  // Classified from the live execute operands so the result is ready at capture
  muldiv_special #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_special (
    .op        (aluCtrlE[2:0]),
    .a         (srcAE),
    .b         (srcBE),
    .is_special(spec_hit),
    .result    (spec_result)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    rd_d     = rd_q;
    res_d    = res_q;
    mulReq   = 1'b0;
    stallMul = 1'b0;
    resValid = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (isMulE && !flushE) begin
          stallMul = 1'b1;
          a_d      = srcAE;
          b_d      = srcBE;
          op_d     = aluCtrlE[2:0];
          rd_d     = rdE;
`ifdef MULDIV_TIMEOUT_EN
          cnt_d    = '0;
`endif
          if (spec_hit) begin
            res_d   = spec_result;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        mulReq   = 1'b1;
        stallMul = 1'b1;
        // A flush wins over a completion arriving in the same cycle
        if (flushE) begin
          state_d = IDLE;
        end else if (mulDone) begin
          res_d   = mulResult;
          state_d = DONE;
`ifdef MULDIV_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          res_d     = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        // The stalled M-op is still visible in E here, so isMulE must not re-issue
        resValid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mulTimeout = timeout_q;
`endif

  assign mulA    = a_q;
  assign mulB    = b_q;
  assign mulOp   = op_q;
  assign resData = res_q;
  assign resRd   = rd_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb/tb_muldiv_issue_ctrl.sv - self-checking bench for muldiv_issue_ctrl (timeout section under MULDIV_TIMEOUT_EN)
module tb_muldiv_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        isMulE;
  logic [3:0]  aluCtrlE;
  logic [31:0] srcAE, srcBE;
  logic [4:0]  rdE;
  logic        flushE;
  logic        mulReq;
  logic [31:0] mulA, mulB;
  logic [2:0]  mulOp;
  logic        mulDone;
  logic [31:0] mulResult;
  logic        stallMul;
  logic        resValid;
  logic [31:0] resData;
  logic [4:0]  resRd;
`ifdef MULDIV_TIMEOUT_EN
  logic        mulTimeout;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  muldiv_issue_ctrl #(
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .isMulE    (isMulE),
    .aluCtrlE  (aluCtrlE),
    .srcAE     (srcAE),
    .srcBE     (srcBE),
    .rdE       (rdE),
    .flushE    (flushE),
    .mulReq    (mulReq),
    .mulA      (mulA),
    .mulB      (mulB),
    .mulOp     (mulOp),
    .mulDone   (mulDone),
    .mulResult (mulResult),
    .stallMul  (stallMul),
    .resValid  (resValid),
    .resData   (resData),
`ifdef MULDIV_TIMEOUT_EN
    .resRd     (resRd),
    .mulTimeout(mulTimeout)
`else
    .resRd     (resRd)
`endif
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    bit          special;
    int          n;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    isMulE    = 1'b0;
    aluCtrlE  = 4'd0;
    srcAE     = 32'h0;
    srcBE     = 32'h0;
    rdE       = 5'd0;
    flushE    = 1'b0;
    mulDone   = 1'b0;
    mulResult = 32'h0BAD_F00D;
  endtask

  task automatic run_vec(input int i);
    string t;
    t = $sformatf("v%0d", i);
    isMulE   = 1'b1;
    aluCtrlE = {1'b0, vecs[i].op};
    srcAE    = vecs[i].a;
    srcBE    = vecs[i].b;
    rdE      = vecs[i].rd;
    mid();
    chk({t, "_issue_stall"}, 32'(stallMul), 32'd1);
    chk({t, "_issue_req"}, 32'(mulReq), 32'd0);
    next();
    if (!vecs[i].special) begin
      for (int c = 1; c <= vecs[i].n; c++) begin
        if (c == vecs[i].n) begin
          mulDone   = 1'b1;
          mulResult = vecs[i].exp;
        end
        mid();
        chk({t, "_wait_req"}, 32'(mulReq), 32'd1);
        chk({t, "_wait_stall"}, 32'(stallMul), 32'd1);
        chk({t, "_wait_valid"}, 32'(resValid), 32'd0);
        if (c == 1) begin
          chk({t, "_mulA"}, mulA, vecs[i].a);
          chk({t, "_mulB"}, mulB, vecs[i].b);
          chk({t, "_mulOp"}, 32'(mulOp), 32'(vecs[i].op));
        end
        next();
        mulDone   = 1'b0;
        mulResult = 32'h0BAD_F00D;
      end
    end
    mid();
    chk({t, "_done_valid"}, 32'(resValid), 32'd1);
    chk({t, "_done_data"}, resData, vecs[i].exp);
    chk({t, "_done_rd"}, 32'(resRd), 32'(vecs[i].rd));
    chk({t, "_done_req"}, 32'(mulReq), 32'd0);
    chk({t, "_done_stall"}, 32'(stallMul), 32'd0);
    next();
    isMulE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          op     a             b             rd     spec n  exp
    vecs[0] = '{3'b000, 32'd7,        32'd6,        5'd5,  0,   3, 32'h0000_002A};
    vecs[1] = '{3'b101, 32'd100,      32'd7,        5'd6,  0,   4, 32'd14};
    vecs[2] = '{3'b111, 32'd100,      32'd7,        5'd7,  0,   2, 32'd2};
    vecs[3] = '{3'b100, 32'h55,       32'h0,        5'd8,  1,   0, 32'hFFFF_FFFF};
    vecs[4] = '{3'b111, 32'h55,       32'h0,        5'd9,  1,   0, 32'h0000_0055};
    vecs[5] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1,  0, 32'h8000_0000};
    vecs[6] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1,  0, 32'h0000_0000};
    vecs[7] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0,  1, 32'h0000_0000};
    vecs[8] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 0,  1, 32'hFFFF_FFFE};
    vecs[9] = '{3'b110, 32'h8000_0000, 32'h0,       5'd31, 1,   0, 32'h8000_0000};

    idle_inputs();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
    mid();
    chk("rst_req", 32'(mulReq), 32'd0);
    chk("rst_valid", 32'(resValid), 32'd0);
    chk("rst_data", resData, 32'd0);
    chk("rst_rd", 32'(resRd), 32'd0);
    chk("rst_mulA", mulA, 32'd0);
    chk("rst_mulB", mulB, 32'd0);
    chk("rst_mulOp", 32'(mulOp), 32'd0);
    chk("rst_stall", 32'(stallMul), 32'd0);
`ifdef MULDIV_TIMEOUT_EN
    chk("rst_timeout", 32'(mulTimeout), 32'd0);
`endif
    next();

    // completion pulse while idle must be ignored
    mulDone   = 1'b1;
    mulResult = 32'h1234_5678;
    next();
    mulDone = 1'b0;
    mid();
    chk("idle_done_valid", 32'(resValid), 32'd0);
    chk("idle_done_data", resData, 32'd0);
    next();

    // flush in IDLE blocks issue
    isMulE   = 1'b1;
    aluCtrlE = 4'b0000;
    srcAE    = 32'd3;
    srcBE    = 32'd4;
    rdE      = 5'd3;
    flushE   = 1'b1;
    mid();
    chk("flush_idle_stall", 32'(stallMul), 32'd0);
    next();
    idle_inputs();
    mid();
    chk("flush_idle_req", 32'(mulReq), 32'd0);
    chk("flush_idle_valid", 32'(resValid), 32'd0);
    chk("flush_idle_mulA", mulA, 32'd0);
    next();

    for (int i = 0; i < NV; i++) run_vec(i);

    // flush on the 3rd WAIT cycle together with mulDone
    isMulE   = 1'b1;
    aluCtrlE = 4'b0000;
    srcAE    = 32'd3;
    srcBE    = 32'd3;
    rdE      = 5'd14;
    next();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        flushE    = 1'b1;
        mulDone   = 1'b1;
        mulResult = 32'd9;
      end
      mid();
      chk($sformatf("flush_wait_req_c%0d", c), 32'(mulReq), 32'd1);
      next();
    end
    idle_inputs();
    mid();
    chk("flush_wait_valid", 32'(resValid), 32'd0);
    chk("flush_wait_stall", 32'(stallMul), 32'd0);
    chk("flush_wait_req", 32'(mulReq), 32'd0);
    chk("flush_wait_data", resData, 32'h8000_0000);
    next();
    mid();
    chk("flush_wait_valid2", 32'(resValid), 32'd0);
    next();

`ifdef MULDIV_TIMEOUT_EN
    isMulE   = 1'b1;
    aluCtrlE = 4'b0000;
    srcAE    = 32'd5;
    srcBE    = 32'd5;
    rdE      = 5'd15;
    next();
    for (int c = 1; c <= 8; c++) begin
      mid();
      chk($sformatf("to_wait_req_c%0d", c), 32'(mulReq), 32'd1);
      next();
    end
    mid();
    chk("to_done_valid", 32'(resValid), 32'd1);
    chk("to_done_data", resData, 32'd0);
    chk("to_done_req", 32'(mulReq), 32'd0);
    chk("to_flag", 32'(mulTimeout), 32'd1);
    next();
    isMulE = 1'b0;
    next();
    next();
    mid();
    chk("to_flag_sticky", 32'(mulTimeout), 32'd1);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    mid();
    chk("to_flag_cleared", 32'(mulTimeout), 32'd0);
    next();
`else
    // without the watchdog WAIT persists until mulDone
    isMulE   = 1'b1;
    aluCtrlE = 4'b0001;
    srcAE    = 32'd5;
    srcBE    = 32'd5;
    rdE      = 5'd15;
    next();
    for (int c = 1; c <= 12; c++) begin
      next();
    end
    mid();
    chk("long_wait_req", 32'(mulReq), 32'd1);
    chk("long_wait_valid", 32'(resValid), 32'd0);
    next();
    mulDone   = 1'b1;
    mulResult = 32'hCAFE_0001;
    next();
    mulDone = 1'b0;
    mid();
    chk("long_wait_done_valid", 32'(resValid), 32'd1);
    chk("long_wait_done_data", resData, 32'hCAFE_0001);
    next();
    isMulE = 1'b0;
    next();
`endif

    // reset in the middle of WAIT
    isMulE   = 1'b1;
    aluCtrlE = 4'b0000;
    srcAE    = 32'd11;
    srcBE    = 32'd13;
    rdE      = 5'd16;
    next();
    isMulE = 1'b0;
    mid();
    chk("midrst_pre_req", 32'(mulReq), 32'd1);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    mid();
    chk("midrst_req", 32'(mulReq), 32'd0);
    chk("midrst_mulA", mulA, 32'd0);
    chk("midrst_data", resData, 32'd0);
    chk("midrst_rd", 32'(resRd), 32'd0);
    chk("midrst_stall", 32'(stallMul), 32'd0);
    next();
    mid();
    chk("midrst_valid", 32'(resValid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
Initiator side of the multi-cycle M-extension handshake. Sits in the execute stage between the hazard unit and the iterative mul/div unit. It captures operands when an M-op reaches execute, holds the level request to the unit, stalls F/D/E until done, and returns one registered writeback result. RISC-V divide special cases are resolved locally without issuing.

Parameters:
DATA_WIDTH, 32, operand/result width
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with MULDIV_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
isMulE  in  1  execute-stage instruction is an M-op
aluCtrlE  in  4  op select; [2:0] = RV32M funct3
srcAE  in  DATA_WIDTH  rs1 value
srcBE  in  DATA_WIDTH  rs2 value
rdE  in  5  destination register
flushE  in  1  squash execute stage
mulReq  out  1  level request to unit, held until done
mulA  out  DATA_WIDTH  latched operand A
mulB  out  DATA_WIDTH  latched operand B
mulOp  out  3  latched funct3
mulDone  in  1  unit completion pulse
mulResult  in  DATA_WIDTH  unit result, valid with mulDone
stallMul  out  1  stall F/D/E
resValid  out  1  one-cycle writeback strobe
resData  out  DATA_WIDTH  result
resRd  out  5  destination register for resData

Behaviour:
- Reset, synchronous, also mid-op: state IDLE; mulReq=0, resValid=0, resData=0, resRd=0, mulA=mulB=0, mulOp=0. stallMul is combinational and 0 after reset.
- State IDLE:
  - isMulE&!flushE latches srcAE, srcBE, aluCtrlE[2:0], rdE.
  - stallMul=1 in this cycle.
  - Special-case ops go to DONE.
  - All other ops go to WAIT.
- Special cases (DIV/DIVU/REM/REMU only):
  - B==0: quotient = all ones, remainder = A.
  - Signed DIV/REM with A=0x80000000, B=0xFFFFFFFF: quotient = A, remainder = 0.
  - mulReq never rises for these ops.
- State WAIT:
  - mulReq=1 and stallMul=1.
  - mulDone latches mulResult into resData and moves to DONE.
- State DONE:
  - resValid=1, resRd=latched rd, mulReq=0, stallMul=0; return to IDLE next cycle.
  - isMulE is ignored in DONE because the stalled instruction is still in E.
  - Guarantees a minimum one-cycle gap with mulReq low between operations.
- Latency: special case stalls 1 cycle and resValid appears in cycle 2. Normal op takes 1 + N unit cycles + 1.
- flushE in WAIT: return to IDLE, mulReq drops, no resValid, any mulDone in that cycle is discarded.
- flushE in IDLE: blocks issue. In DONE it has no effect; the result is still strobed and the hazard unit gates it.
- mulDone outside WAIT is ignored.
- resData holds its value after DONE until the next capture.

Optional Feature:
Macro MULDIV_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT. Reaching TIMEOUT_CYCLES forces DONE with resData=0 and drops mulReq.
  - Adds output port mulTimeout (1 bit), a sticky flag cleared only by rst.
- Without the macro: no counter, no port, and WAIT lasts until mulDone.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 constants MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - State enum IDLE/WAIT/DONE.
  - Helper function is_div(op).
- One sub-module, muldiv_special: combinational detection of the special cases and their result.

Test Plan:
- MUL 7×6, rd=5 -> mulReq high until mulDone; resValid=1 with resData=42 (0x2A) and resRd=5; stallMul low in DONE.
- DIVU 100/7 -> resData=14; then REMU 100/7 -> resData=2; mulReq low for at least one cycle between the two ops.
- DIV 0x55/0 -> resData=0xFFFFFFFF after 1 stall cycle, mulReq never 1. REMU 0x55/0 -> resData=0x55.
- DIV 0x80000000/0xFFFFFFFF -> resData=0x80000000. REM with the same operands -> resData=0. No issue in either case.
- MUL issued, flushE pulsed on the 3rd WAIT cycle with mulDone the same cycle -> IDLE, no resValid, stallMul=0 next cycle.
- With MULDIV_TIMEOUT_EN, TIMEOUT_CYCLES=8 and mulDone held 0 -> DONE after 8 WAIT cycles, resData=0, mulTimeout=1 until rst.
